regbank: RTL and testbench
==========================

Name: regbank

Overview:
- Architectural register bank sitting directly downstream of the control unit.
- Consumes the control unit's write-enable, register-select and 64-bit write-value outputs, and stores them in a 64 x 64-bit flop array.
- Provides two synchronous read ports for the datapath.
- Includes a sequenced bulk-clear engine, so software-visible state is wiped one register per cycle without a global reset.

Parameters:
- NREGS, 64: number of registers. Must be a power of two, at most 64.
- WIDTH, 64: register width in bits.
- SEL_W, 6: select width; equals log2(NREGS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request; driven from the control unit's regbank_we.
- wr_sel  in  SEL_W  write register index; driven from regbank_sel.
- wr_data  in  WIDTH  write value; driven from regbank_valout.
- rd_sel_a  in  SEL_W  read port A index.
- rd_sel_b  in  SEL_W  read port B index.
- rd_data_a  out  WIDTH  read port A data, registered.
- rd_data_b  out  WIDTH  read port B data, registered.
- clr_req  in  1  single-cycle request to clear the whole bank.
- busy  out  1  high while the clear sequence runs.
- wr_drop  out  1  one-cycle pulse when a write is discarded because busy is high.
- valid_mask  out  NREGS  bit i set means register i has been written since the last reset or clear.
- rd_perr_a  out  1  parity error on port A. Tied 0 unless REGBANK_PARITY_EN is defined.
- rd_perr_b  out  1  parity error on port B. Same condition as rd_perr_a.

Behaviour:
- Reset:
  - rst high asynchronously sets all registers, rd_data_a, rd_data_b, valid_mask, busy, wr_drop and clr_ptr to 0, and the state to IDLE.
  - Takes effect immediately, including in the middle of a clear; the bank then re-enters IDLE with everything zero.
- States: IDLE and CLEAR. busy is a registered output, equal to 1 exactly when the state is CLEAR.
- Write in IDLE:
  - wr_en=1 on a rising edge writes regs[wr_sel] <= wr_data and sets valid_mask[wr_sel].
  - The new value is visible to reads issued in the same cycle through the bypass (see Read).
- Write in CLEAR:
  - The write is ignored and wr_drop=1 for the next cycle.
  - The producer must hold the control op until busy=0; this block never stalls the producer.
- Read:
  - Latency is 1 cycle: rd_data_x <= regs[rd_sel_x].
  - Write-first bypass: if a write is accepted in the same cycle and wr_sel==rd_sel_x, rd_data_x <= wr_data.
  - Both ports may select the same register.
  - Reads during CLEAR return current contents, so already-cleared registers read 0.
- Clear sequence:
  - clr_req=1 in IDLE moves the state to CLEAR with clr_ptr=0.
  - Each CLEAR cycle: regs[clr_ptr] <= 0, valid_mask[clr_ptr] <= 0, clr_ptr++.
  - When clr_ptr==NREGS-1, that register is cleared and the next state is IDLE.
  - Total: busy is high for exactly NREGS cycles.
  - clr_req while in CLEAR is ignored; there is no restart.
- Simultaneous clr_req and wr_en in IDLE: the write commits in that cycle, CLEAR starts in the next cycle, and the written value is subsequently wiped.
- clr_ptr is SEL_W bits wide and wraps to 0 on exit from CLEAR.
- Out-of-range indices cannot occur when NREGS == 2^SEL_W.

Optional Feature:
- Macro: REGBANK_PARITY_EN.
- When defined:
  - Each register gets an extra parity bit, set on write to the XOR-reduction of wr_data and cleared to 0 on clear or reset.
  - On read, rd_perr_x is registered alongside rd_data_x and equals 1 when the stored parity does not match the XOR-reduction of the stored data.
  - Bypassed reads always report rd_perr_x=0.
- When undefined: no parity storage; rd_perr_a and rd_perr_b are constant 0.
- Ports are identical in both builds.

Decomposition:
- regbank_pkg contains:
  - the regbank_state_t enum {IDLE, CLEAR};
  - localparams NREGS, WIDTH, SEL_W;
  - the typedefs reg_sel_t (logic [SEL_W-1:0]) and reg_word_t (logic [WIDTH-1:0]).
- The control unit imports the same typedefs, so the select and data widths match on both sides.
- One sub-module, regbank_clr_fsm: holds the state, clr_ptr and busy, and outputs clr_active and clr_idx.
- The storage array and bypass logic stay in regbank.

Test Plan:
- Reset then read: assert rst, release, read r5 -> rd_data_a=0, valid_mask=0, busy=0.
- Write then read: write r3=64'hDEADBEEF_CAFEF00D; next cycle read r3 on port A -> rd_data_a=64'hDEADBEEF_CAFEF00D one cycle later, valid_mask[3]=1.
- Same-cycle bypass: write r7=64'h1234 while rd_sel_a=rd_sel_b=7 -> both ports show 64'h1234 next cycle.
- Clear sequence:
  - Fill r0..r63 with index+1, then pulse clr_req.
  - Expect busy high for exactly 64 cycles.
  - A write to r10 during CLEAR gives wr_drop=1.
  - After the clear, every register reads 0 and valid_mask=0.
- Simultaneous events and reset mid-clear:
  - clr_req together with a write of r2=9 -> r2=9 for one cycle, then 0 after the clear.
  - Assert rst at clear cycle 20 -> busy=0 immediately and all registers read 0.
- Parity (REGBANK_PARITY_EN): write r1=64'h1, then force its stored parity bit -> reading r1 gives rd_perr_a=1; an unforced r4 gives rd_perr_a=0.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared types and sizing for the architectural register bank.
// The control unit imports the same typedefs so select and data widths agree
// on both sides of the interface.
//   NREGS : number of registers (power of two, at most 64)
//   WIDTH : register width in bits
//   SEL_W : select width, log2(NREGS)
// Optional build macro used by the bank: REGBANK_PARITY_EN.
package regbank_pkg;

  localparam int NREGS = 64;
  localparam int WIDTH = 64;
  localparam int SEL_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } regbank_state_t;

  typedef logic [SEL_W-1:0] reg_sel_t;
  typedef logic [WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regbank_clr_fsm.sv
// regbank_clr_fsm: sequencer for the bulk-clear engine. Walks a pointer over
// every register, one per cycle, while the bank is in CLEAR.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr_req     : single-cycle clear request (ignored while clearing)
//   clr_active  : high while in CLEAR; the bank clears regs[clr_idx] this cycle
//   clr_idx     : register being cleared this cycle
//   busy        : registered flag, high exactly while the state is CLEAR
module regbank_clr_fsm
  import regbank_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clr_req,
  output logic     clr_active,
  output reg_sel_t clr_idx,
  output logic     busy
);

  localparam reg_sel_t LAST_IDX = reg_sel_t'(NREGS - 1);

  regbank_state_t state;
  regbank_state_t state_next;
  reg_sel_t       clr_ptr;
  reg_sel_t       clr_ptr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_ptr <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      // busy is registered from the next state so it tracks CLEAR exactly.
      busy    <= (state_next == CLEAR);
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      CLEAR: begin
        // Explicit wrap keeps the pointer in range even when NREGS < 2**SEL_W.
        if (clr_ptr == LAST_IDX) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        clr_ptr_next = '0;
      end
    endcase
  end

  assign clr_active = (state == CLEAR);
  assign clr_idx    = clr_ptr;

endmodule

// File: rtl/regbank.sv
// regbank: architectural register bank downstream of the control unit.
// NREGS x WIDTH flop array, one write port, two registered read ports with
// write-first bypass, and a sequenced bulk clear (one register per cycle).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   wr_en/wr_sel/wr_data : write request from the control unit
//   rd_sel_a, rd_sel_b   : read indices
//   rd_data_a, rd_data_b : registered read data (1-cycle latency)
//   clr_req              : single-cycle bulk-clear request
//   busy                 : high while the clear sequence runs
//   wr_drop              : pulse when a write was discarded during a clear
//   valid_mask           : bit i set when register i written since reset/clear
//   rd_perr_a, rd_perr_b : read parity errors (constant 0 unless
//                          REGBANK_PARITY_EN is defined)
// Build macro: REGBANK_PARITY_EN adds one stored parity bit per register.
module regbank
  import regbank_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  reg_sel_t         wr_sel,
  input  reg_word_t        wr_data,
  input  reg_sel_t         rd_sel_a,
  input  reg_sel_t         rd_sel_b,
  output reg_word_t        rd_data_a,
  output reg_word_t        rd_data_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_drop,
  output logic [NREGS-1:0] valid_mask,
  output logic             rd_perr_a,
  output logic             rd_perr_b
);

  logic      clr_active;
  reg_sel_t  clr_idx;
  logic      wr_acc;
  logic      byp_a;
  logic      byp_b;
  reg_word_t regs [NREGS];

  regbank_clr_fsm u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .clr_active (clr_active),
    .clr_idx    (clr_idx),
    .busy       (busy)
  );

  // Writes are only accepted outside the clear sequence; the producer is
  // expected to hold its op until busy drops.
  assign wr_acc = wr_en & ~clr_active;
  assign byp_a  = wr_acc & (wr_sel == rd_sel_a);
  assign byp_b  = wr_acc & (wr_sel == rd_sel_b);

  // Storage and valid tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      valid_mask <= '0;
      wr_drop    <= 1'b0;
    end else begin
      wr_drop <= wr_en & clr_active;
      if (clr_active) begin
        regs[clr_idx]       <= '0;
        valid_mask[clr_idx] <= 1'b0;
      end else if (wr_en) begin
        regs[wr_sel]       <= wr_data;
        valid_mask[wr_sel] <= 1'b1;
      end
    end
  end

  // Read ports: write-first bypass, otherwise the pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= byp_a ? wr_data : regs[rd_sel_a];
      rd_data_b <= byp_b ? wr_data : regs[rd_sel_b];
    end
  end

`ifdef REGBANK_PARITY_EN
  // One parity bit per register, kept alongside the data; a bypassed read
  // never reports an error since the data did not come from storage.
  logic [NREGS-1:0] par_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bits  <= '0;
      rd_perr_a <= 1'b0;
      rd_perr_b <= 1'b0;
    end else begin
      if (clr_active) begin
        par_bits[clr_idx] <= 1'b0;
      end else if (wr_en) begin
        par_bits[wr_sel] <= ^wr_data;
      end
      rd_perr_a <= byp_a ? 1'b0 : (par_bits[rd_sel_a] ^ (^regs[rd_sel_a]));
      rd_perr_b <= byp_b ? 1'b0 : (par_bits[rd_sel_b] ^ (^regs[rd_sel_b]));
    end
  end
`else
  assign rd_perr_a = 1'b0;
  assign rd_perr_b = 1'b0;
`endif

endmodule

// File: tb/tb_regbank.sv
module tb_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_sel = '0;
  logic [63:0] wr_data = '0;
  logic [5:0]  rd_sel_a = '0;
  logic [5:0]  rd_sel_b = '0;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        wr_drop;
  logic [63:0] valid_mask;
  logic        rd_perr_a;
  logic        rd_perr_b;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain array plus "clear in progress" bookkeeping.
  logic [63:0] m_regs [64];
  bit          m_written [64];
  bit          m_clearing;
  int          m_clr_pos;
  logic [63:0] e_rd_a, e_rd_b;
  bit          e_drop;

  regbank dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .rd_sel_a   (rd_sel_a),
    .rd_sel_b   (rd_sel_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .clr_req    (clr_req),
    .busy       (busy),
    .wr_drop    (wr_drop),
    .valid_mask (valid_mask),
    .rd_perr_a  (rd_perr_a),
    .rd_perr_b  (rd_perr_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_mask();
    logic [63:0] m = '0;
    for (int i = 0; i < 64; i++) m[i] = m_written[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_regs[i]    = '0;
      m_written[i] = 1'b0;
    end
    m_clearing = 1'b0;
    m_clr_pos  = 0;
    e_rd_a     = '0;
    e_rd_b     = '0;
    e_drop     = 1'b0;
  endtask

  // One clock: inputs already set; predict, clock, compare, advance model.
  task automatic step(input string tag);
    bit accepted;
    accepted = wr_en && !m_clearing;
    e_rd_a = (accepted && wr_sel == rd_sel_a) ? wr_data : m_regs[rd_sel_a];
    e_rd_b = (accepted && wr_sel == rd_sel_b) ? wr_data : m_regs[rd_sel_b];
    e_drop = wr_en && m_clearing;
    if (m_clearing) begin
      m_regs[m_clr_pos]    = '0;
      m_written[m_clr_pos] = 1'b0;
      m_clr_pos++;
      if (m_clr_pos == 64) m_clearing = 1'b0;
    end else begin
      if (wr_en) begin
        m_regs[wr_sel]    = wr_data;
        m_written[wr_sel] = 1'b1;
      end
      if (clr_req) begin
        m_clearing = 1'b1;
        m_clr_pos  = 0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".rd_a"}, rd_data_a, e_rd_a);
    check({tag, ".rd_b"}, rd_data_b, e_rd_b);
    check({tag, ".busy"}, {63'b0, busy}, {63'b0, m_clearing});
    check({tag, ".drop"}, {63'b0, wr_drop}, {63'b0, e_drop});
    check({tag, ".mask"}, valid_mask, model_mask());
    check({tag, ".perr"}, {62'b0, rd_perr_a, rd_perr_b}, 64'b0);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    idle_inputs();
    for (int i = 0; i < 64; i += 2) begin
      rd_sel_a = 6'(i); rd_sel_b = 6'(i + 1);
      step(tag);
      check({tag, ".zero_a"}, rd_data_a, 64'b0);
      check({tag, ".zero_b"}, rd_data_b, 64'b0);
    end
  endtask

  initial begin
    int n;
    model_reset();

    // Reset then read
    rst = 1'b1;
    #1;
    check("rst.busy", {63'b0, busy}, 64'b0);
    check("rst.mask", valid_mask, 64'b0);
    check("rst.rd_a", rd_data_a, 64'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_sel_a = 6'd5;
    step("rd_r5");
    check("rd_r5.value", rd_data_a, 64'b0);

    // Write then read
    wr_en = 1'b1; wr_sel = 6'd3; wr_data = 64'hDEADBEEF_CAFEF00D; rd_sel_a = 6'd0;
    step("wr_r3");
    idle_inputs(); rd_sel_a = 6'd3;
    step("rd_r3");
    check("rd_r3.value", rd_data_a, 64'hDEADBEEF_CAFEF00D);
    check("rd_r3.mask3", {63'b0, valid_mask[3]}, 64'd1);

    // Same-cycle bypass on both ports
    wr_en = 1'b1; wr_sel = 6'd7; wr_data = 64'h1234; rd_sel_a = 6'd7; rd_sel_b = 6'd7;
    step("byp");
    check("byp.a", rd_data_a, 64'h1234);
    check("byp.b", rd_data_b, 64'h1234);

    // Fill with index+1, then clear
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_sel = 6'(i); wr_data = 64'(i + 1);
      rd_sel_a = 6'($urandom_range(0, 63)); rd_sel_b = 6'($urandom_range(0, 63));
      step("fill");
    end
    check("fill.mask", valid_mask, {64{1'b1}});
    wr_en = 1'b0; clr_req = 1'b1;
    step("clr_go");
    clr_req = 1'b0;
    n = busy ? 1 : 0;
    for (int c = 0; c < 100 && busy; c++) begin
      wr_en = (c == 5); wr_sel = 6'd10; wr_data = 64'hBAD;
      rd_sel_a = 6'($urandom_range(0, 63)); rd_sel_b = 6'd63;
      step("clr_run");
      if (c == 5) check("clr.wr_drop", {63'b0, wr_drop}, 64'd1);
      if (busy) n++;
    end
    check("clr.busy_cycles", 64'(n), 64'd64);
    check("clr.mask", valid_mask, 64'b0);
    read_all_zero("after_clr");

    // Simultaneous clr_req and write r2=9
    wr_en = 1'b1; wr_sel = 6'd2; wr_data = 64'd9; clr_req = 1'b1;
    step("clr_wr");
    idle_inputs(); rd_sel_a = 6'd2;
    step("clr_wr_rd");
    check("clr_wr.r2_live", rd_data_a, 64'd9);
    for (int c = 0; c < 100 && busy; c++) step("clr_wr_run");
    step("clr_wr_after");
    check("clr_wr.r2_gone", rd_data_a, 64'd0);

    // Reset in the middle of a clear
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_sel = 6'(40 + i); wr_data = {$urandom, $urandom};
      step("pre_mid");
    end
    wr_en = 1'b0; clr_req = 1'b1;
    step("mid_go");
    clr_req = 1'b0;
    for (int c = 0; c < 20; c++) step("mid_run");
    rst = 1'b1;
    #1;
    check("mid.busy", {63'b0, busy}, 64'b0);
    check("mid.mask", valid_mask, 64'b0);
    model_reset();
    #2 rst = 1'b0;
    read_all_zero("mid_after");

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_sel   = 6'($urandom_range(0, 63));
      wr_data  = {$urandom, $urandom};
      rd_sel_a = ($urandom_range(0, 3) == 0) ? wr_sel : 6'($urandom_range(0, 63));
      rd_sel_b = ($urandom_range(0, 3) == 0) ? wr_sel : 6'($urandom_range(0, 63));
      clr_req  = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
